memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/nes_mem_pkg.sv | 19 +
 rtl/mem_arb_select.sv | 47 ++++
 rtl/memory_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_mem_pkg.sv
// Shared types and default widths for the NES video-memory arbiter.
package nes_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PPU,
    CPU,
    DBG
  } req_e;

endpackage

// File: rtl/mem_arb_select.sv
// Fixed-priority pick (PPU > CPU > DBG) with a debug starvation override.
module mem_arb_select
  import nes_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en,
  input  logic ppu_req,
  input  logic cpu_req,
  input  logic dbg_req,
  output req_e grant_c,
  output logic any_req_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             cnt_at_limit;
  logic             starved;

  assign cnt_at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign starved      = dbg_req && cnt_at_limit;
  assign any_req_c    = ppu_req || cpu_req || dbg_req;

  always_comb begin
    grant_c = DBG;
    if (starved)      grant_c = DBG;
    else if (ppu_req) grant_c = PPU;
    else if (cpu_req) grant_c = CPU;
  end

  // Counts arbitrations debug lost; only meaningful while the arbiter is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!dbg_req || grant_c == DBG) begin
        starve_cnt <= '0;
      end else if (!cnt_at_limit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Three-requester synchronous-RAM arbiter: one access every three cycles
// (arbitrate, access, acknowledge).
module memory_arbiter
  import nes_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ppu_req,
  input  logic [ADDR_W-1:0] i_ppu_addr,
  output logic              o_ppu_ack,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  state_e            state;
  req_e              owner;
  req_e              grant;
  logic              any_req;
  logic              arb_en;
  logic              write_q;
  logic [DATA_W-1:0] rdata_q;

  assign arb_en = (state == IDLE);

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .arb_en   (arb_en),
    .ppu_req  (i_ppu_req),
    .cpu_req  (i_cpu_req),
    .dbg_req  (i_dbg_req),
    .grant_c  (grant),
    .any_req_c(any_req)
  );

  // RAM data arrives during DONE; show it live with the ack, then hold it.
  assign o_rdata = (state == DONE && !write_q) ? i_mem_rdata : rdata_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      owner       <= PPU;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      o_busy      <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_ppu_ack   <= 1'b0;
      o_cpu_ack   <= 1'b0;
      o_dbg_ack   <= 1'b0;
    end else begin
      o_ppu_ack <= 1'b0;
      o_cpu_ack <= 1'b0;
      o_dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ACCESS;
            owner    <= grant;
            o_busy   <= 1'b1;
            o_mem_en <= 1'b1;
            case (grant)
              PPU: begin
                write_q     <= 1'b0;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_ppu_addr;
                o_mem_wdata <= '0;
              end
              CPU: begin
                write_q     <= i_cpu_we;
                o_mem_we    <= i_cpu_we;
                o_mem_addr  <= i_cpu_addr;
                o_mem_wdata <= i_cpu_wdata;
              end
              default: begin
                write_q     <= i_dbg_we;
                o_mem_we    <= i_dbg_we;
                o_mem_addr  <= i_dbg_addr;
                o_mem_wdata <= i_dbg_wdata;
              end
            endcase
          end
        end
        ACCESS: begin
          state     <= DONE;
          o_mem_en  <= 1'b0;
          o_mem_we  <= 1'b0;
          o_ppu_ack <= (owner == PPU);
          o_cpu_ack <= (owner == CPU);
          o_dbg_ack <= (owner == DBG);
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          if (!write_q) rdata_q <= i_mem_rdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a cycle-level reference model predicts
// each grant, and a monitor checks accesses, acks and read data as they occur.
module tb_memory_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int          LIMIT = 15;

  logic          clk;
  logic          rst_n;
  logic          ppu_req, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] ppu_addr, cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          ppu_ack, cpu_ack, dbg_ack;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ppu_req(ppu_req), .i_ppu_addr(ppu_addr), .o_ppu_ack(ppu_ack),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack),
    .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            who;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          ne, cur, got;
  int            checks = 0;
  int            fails = 0;
  int            cyc = 0;
  int            mphase = 0;
  int            starve = 0;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] ram     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Synchronous RAM seen by the DUT.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: arbitrate from the pins every third cycle when idle.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mphase  = 0;
      starve  = 0;
      last_rd = '0;
      exp_q.delete();
    end else begin
      case (mphase)
        0: begin
          if (!dbg_req) starve = 0;
          if (ppu_req || cpu_req || dbg_req) begin
            if (dbg_req && starve == LIMIT) ne.who = 2;
            else if (ppu_req)               ne.who = 0;
            else if (cpu_req)               ne.who = 1;
            else                            ne.who = 2;
            if (dbg_req) starve = (ne.who == 2) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
            case (ne.who)
              0:       begin ne.we = 1'b0;   ne.addr = ppu_addr; ne.wdata = '0;        end
              1:       begin ne.we = cpu_we; ne.addr = cpu_addr; ne.wdata = cpu_wdata; end
              default: begin ne.we = dbg_we; ne.addr = dbg_addr; ne.wdata = dbg_wdata; end
            endcase
            ne.rdata   = ne.we ? '0 : ref_mem[ne.addr];
            ne.acc_cyc = cyc;
            cur        = ne;
            exp_q.push_back(ne);
            mphase     = 1;
          end
        end
        1: begin
          if (cur.we) ref_mem[cur.addr] = cur.wdata;
          mphase = 2;
        end
        default: mphase = 0;
      endcase
    end
  end

  // Monitor: compare every presented access and ack against the scoreboard.
  always @(negedge clk) begin
    int nack;
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(mphase != 0));
      chk("mem_en", 32'(mem_en), 32'(mphase == 1));
      if (mem_en) begin
        if (exp_q.size() == 0) flag("unexpected memory access");
        else begin
          chk("access_cycle", 32'(cyc), 32'(exp_q[0].acc_cyc));
          chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
          chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
          if (exp_q[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].wdata));
        end
      end
      nack = int'(ppu_ack) + int'(cpu_ack) + int'(dbg_ack);
      chk("single_ack", 32'(nack <= 1), 32'(1));
      if (nack != 0) begin
        if (exp_q.size() == 0) flag("unexpected ack");
        else begin
          got = exp_q.pop_front();
          chk("ack_who", 32'(ppu_ack ? 0 : (cpu_ack ? 1 : 2)), 32'(got.who));
          chk("ack_cycle", 32'(cyc), 32'(got.acc_cyc + 1));
          if (!got.we) begin
            chk("ack_rdata", 32'(rdata), 32'(got.rdata));
            last_rd = got.rdata;
          end
        end
      end else begin
        chk("rdata_hold", 32'(rdata), 32'(last_rd));
      end
    end
  end

  task automatic wait_ack(input int who, input int limit, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((who == 0 && ppu_ack) || (who == 1 && cpu_ack) || (who == 2 && dbg_ack)) break;
      if (n >= limit) begin
        flag($sformatf("wait_ack requester %0d: no ack within %0d cycles", who, limit));
        break;
      end
    end
  endtask

  task automatic wait_access();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_en) return;
    end
    flag("wait_access: no memory access within 10 cycles");
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ppu_ack"}, 32'(ppu_ack), 0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
    chk({tag, "_dbg_ack"}, 32'(dbg_ack), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    int n;
    int losses;
    bit done;
    bit pend [3];
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = DW'(i ^ (i >> 8));
      ref_mem[i] = DW'(i ^ (i >> 8));
    end
    mem_rdata = '0;
    rst_n = 1'b0;
    ppu_req = 0; cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0;
    ppu_addr = '0; cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // CPU write then read-back of the same location
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'hA5;
    wait_ack(1, 10, n);
    chk("cpu_write_latency", 32'(n), 2);
    cpu_we = 0;
    wait_ack(1, 10, n);
    chk("cpu_read_latency", 32'(n), 3);
    chk("cpu_read_data", 32'(rdata), 32'h00A5);
    cpu_req = 0;
    repeat (2) @(negedge clk);

    // All three at once: PPU, CPU, DEBUG at N+2, N+5, N+8
    ppu_req = 1; ppu_addr = 16'h0201;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0202; cpu_wdata = 8'h5A;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0200;
    wait_ack(0, 10, n); chk("simul_ppu_latency", 32'(n), 2); ppu_req = 0;
    wait_ack(1, 10, n); chk("simul_cpu_latency", 32'(n), 3); cpu_req = 0;
    wait_ack(2, 10, n); chk("simul_dbg_latency", 32'(n), 3); dbg_req = 0;
    chk("simul_dbg_rdata", 32'(rdata), 32'h00A5);
    repeat (2) @(negedge clk);

    // Debug starvation: PPU and CPU alternate, debug held high
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0202;
    ppu_req = 1; ppu_addr = 16'h0210; cpu_we = 0;
    losses = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (dbg_ack) done = 1;
      else if (ppu_ack) begin
        losses++; ppu_req = 0; cpu_req = 1; cpu_addr = AW'(16'h0220 + i);
      end else if (cpu_ack) begin
        losses++; cpu_req = 0; ppu_req = 1; ppu_addr = AW'(16'h0230 + i);
      end
    end
    if (!done) flag("starvation: debug never granted");
    chk("starve_losses", 32'(losses), 32'(LIMIT));
    chk("starve_dbg_rdata", 32'(rdata), 32'h005A);
    ppu_req = 0; cpu_req = 0; dbg_req = 0;
    repeat (2) @(negedge clk);
    // counter cleared: debug loses to PPU again
    dbg_req = 1; ppu_req = 1; ppu_addr = 16'h0203;
    wait_ack(0, 10, n); chk("post_starve_ppu_first", 32'(n), 2); ppu_req = 0;
    wait_ack(2, 10, n); chk("post_starve_dbg_next", 32'(n), 3); dbg_req = 0;
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0300; cpu_wdata = 8'h3C;
    wait_access();
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midreset");
    @(negedge clk);
    chk("midreset_no_ack", 32'(cpu_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1, 10, n);
    chk("reissue_latency", 32'(n), 2);
    cpu_we = 0;
    wait_ack(1, 10, n);
    chk("reissue_readback", 32'(rdata), 32'h003C);
    cpu_req = 0;
    repeat (2) @(negedge clk);

    // CPU drops req during ACCESS; PPU arrives in DONE
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
    wait_access();
    cpu_req = 0;
    @(negedge clk);
    chk("dropped_cpu_ack", 32'(cpu_ack), 1);
    ppu_req = 1; ppu_addr = 16'h0202;
    wait_ack(0, 10, n);
    chk("done_ppu_latency", 32'(n), 3);
    ppu_req = 0;
    repeat (2) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3; i++) pend[i] = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (pend[0] && (ppu_ack || $urandom_range(0, 31) == 0)) begin pend[0] = 0; ppu_req = 0; end
      if (pend[1] && (cpu_ack || $urandom_range(0, 31) == 0)) begin pend[1] = 0; cpu_req = 0; end
      if (pend[2] && (dbg_ack || $urandom_range(0, 31) == 0)) begin pend[2] = 0; dbg_req = 0; end
      if (!pend[0] && $urandom_range(0, 3) == 0) begin
        pend[0] = 1; ppu_req = 1; ppu_addr = AW'(16'h0200 + $urandom_range(0, 7));
      end
      if (!pend[1] && $urandom_range(0, 3) == 0) begin
        pend[1] = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'(16'h0200 + $urandom_range(0, 7)); cpu_wdata = DW'($urandom);
      end
      if (!pend[2] && $urandom_range(0, 2) == 0) begin
        pend[2] = 1; dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = AW'(16'h0200 + $urandom_range(0, 7)); dbg_wdata = DW'($urandom);
      end
    end
    ppu_req = 0; cpu_req = 0; dbg_req = 0;
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
